// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the division controller: FSM state encoding,
// display error pattern, default widths and small state-class helpers.
// Optional remainder path is enabled with the macro DIVCTRL_RESTO_EN.
package div_ctrl_pkg;

    localparam int          W_DEFAULT       = 7;
    localparam int          TIMEOUT_DEFAULT = 255;
    localparam int          BCD_W           = 16;
    localparam logic [15:0] ERR_PATTERN     = 16'hEEEE;

    typedef enum logic [3:0] {
        IDLE,
        DIV_START,
        DIV_WAIT,
        BCDQ_START,
        BCDQ_WAIT,
`ifdef DIVCTRL_RESTO_EN
        BCDR_START,
        BCDR_WAIT,
`endif
        SHOW,
        ERR
    } state_e;

    // States that issue a start pulse; the watchdog is cleared here so it
    // starts from zero in the wait state that always follows.
    function automatic logic is_start(input state_e s);
`ifdef DIVCTRL_RESTO_EN
        return (s == DIV_START) || (s == BCDQ_START) || (s == BCDR_START);
`else
        return (s == DIV_START) || (s == BCDQ_START);
`endif
    endfunction

    // States that wait for a done handshake and are guarded by the watchdog.
    function automatic logic is_wait(input state_e s);
`ifdef DIVCTRL_RESTO_EN
        return (s == DIV_WAIT) || (s == BCDQ_WAIT) || (s == BCDR_WAIT);
`else
        return (s == DIV_WAIT) || (s == BCDQ_WAIT);
`endif
    endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Watchdog for the division controller handshakes. Counts cycles spent in a
// wait state and flags expiry on the TIMEOUT_CYC-th waiting cycle.
module ctrl_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  LAST = CW'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while waiting and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is evaluated in the last allowed waiting cycle so the FSM can
    // still let a same-cycle done take priority.
    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/control_division.sv
// Division controller: accepts an operand pair, runs an external divider,
// converts the quotient (and optionally the remainder) to BCD through a
// shared converter and presents the result on a registered display word.
// Macro DIVCTRL_RESTO_EN enables the remainder path and ver_resto selection.
module control_division
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
    parameter int W           = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [W-1:0] dividendo_in,
    input  logic [W-1:0] divisor_in,
    input  logic         ver_resto,
    output logic         div_start,
    output logic [W-1:0] div_dividendo,
    output logic [W-1:0] div_divisor,
    input  logic         div_done,
    input  logic [W-1:0] div_cociente,
    input  logic [W-1:0] div_resto,
    output logic         bcd_start,
    output logic [W-1:0] bcd_bin,
    input  logic         bcd_done,
    input  logic [15:0]  bcd_digits,
    output logic [15:0]  digito,
    output logic         busy,
    output logic         result_valid,
    output logic         error
);

    state_e         state_q;
    logic [W-1:0]   dvd_q;
    logic [W-1:0]   dvs_q;
    logic [W-1:0]   bin_q;
    logic [15:0]    bcdq_q;
    logic [15:0]    digito_q;
    logic           div_start_q;
    logic           bcd_start_q;
    logic           busy_q;
    logic           valid_q;
    logic           error_q;

`ifdef DIVCTRL_RESTO_EN
    logic [W-1:0]   rem_q;
    logic [15:0]    bcdr_q;
`else
    // Remainder inputs have no consumer in the quotient-only build.
    logic           unused_resto;
    assign unused_resto = ^{ver_resto, div_resto};
`endif

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign wd_clear  = is_start(state_q);
    assign wd_enable = is_wait(state_q);

    ctrl_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Control FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            bin_q       <= '0;
            bcdq_q      <= '0;
            digito_q    <= '0;
            div_start_q <= 1'b0;
            bcd_start_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
`ifdef DIVCTRL_RESTO_EN
            rem_q       <= '0;
            bcdr_q      <= '0;
`endif
        end else begin
            // Start strobes are single-cycle unless re-armed below.
            div_start_q <= 1'b0;
            bcd_start_q <= 1'b0;

            case (state_q)
                IDLE, SHOW, ERR: begin
                    if (op_valid) begin
                        dvd_q   <= dividendo_in;
                        dvs_q   <= divisor_in;
                        valid_q <= 1'b0;
                        if (divisor_in == '0) begin
                            state_q  <= ERR;
                            busy_q   <= 1'b0;
                            error_q  <= 1'b1;
                            digito_q <= ERR_PATTERN;
                        end else begin
                            state_q     <= DIV_START;
                            div_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            error_q     <= 1'b0;
                            digito_q    <= '0;
                        end
                    end else if (state_q == SHOW) begin
`ifdef DIVCTRL_RESTO_EN
                        digito_q <= ver_resto ? bcdr_q : bcdq_q;
`else
                        digito_q <= bcdq_q;
`endif
                    end
                end

                DIV_START: begin
                    state_q <= DIV_WAIT;
                end

                DIV_WAIT: begin
                    if (div_done) begin
                        bin_q       <= div_cociente;
`ifdef DIVCTRL_RESTO_EN
                        rem_q       <= div_resto;
`endif
                        bcd_start_q <= 1'b1;
                        state_q     <= BCDQ_START;
                    end else if (wd_expired) begin
                        state_q  <= ERR;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                        digito_q <= ERR_PATTERN;
                    end
                end

                BCDQ_START: begin
                    state_q <= BCDQ_WAIT;
                end

                BCDQ_WAIT: begin
                    if (bcd_done) begin
                        bcdq_q <= bcd_digits;
`ifdef DIVCTRL_RESTO_EN
                        bin_q       <= rem_q;
                        bcd_start_q <= 1'b1;
                        state_q     <= BCDR_START;
`else
                        state_q  <= SHOW;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        digito_q <= bcd_digits;
`endif
                    end else if (wd_expired) begin
                        state_q  <= ERR;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                        digito_q <= ERR_PATTERN;
                    end
                end

`ifdef DIVCTRL_RESTO_EN
                BCDR_START: begin
                    state_q <= BCDR_WAIT;
                end

                BCDR_WAIT: begin
                    if (bcd_done) begin
                        bcdr_q   <= bcd_digits;
                        state_q  <= SHOW;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        digito_q <= ver_resto ? bcd_digits : bcdq_q;
                    end else if (wd_expired) begin
                        state_q  <= ERR;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                        digito_q <= ERR_PATTERN;
                    end
                end
`endif

                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    error_q  <= 1'b0;
                    digito_q <= '0;
                end
            endcase
        end
    end

    assign div_start     = div_start_q;
    assign div_dividendo = dvd_q;
    assign div_divisor   = dvs_q;
    assign bcd_start     = bcd_start_q;
    assign bcd_bin       = bin_q;
    assign digito        = digito_q;
    assign busy          = busy_q;
    assign result_valid  = valid_q;
    assign error         = error_q;

endmodule

// File: tb/tb_control_division.sv
// Directed bench for control_division: the divider and BCD converter are
// stood in for by inline handshake steps; expected values are hand-computed.
module tb_control_division;

    localparam int W  = 7;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [W-1:0] dividendo_in = '0;
    logic [W-1:0] divisor_in = '0;
    logic         ver_resto = 1'b0;
    logic         div_done = 1'b0;
    logic [W-1:0] div_cociente = '0;
    logic [W-1:0] div_resto = '0;
    logic         bcd_done = 1'b0;
    logic [15:0]  bcd_digits = '0;

    wire          div_start;
    wire [W-1:0]  div_dividendo;
    wire [W-1:0]  div_divisor;
    wire          bcd_start;
    wire [W-1:0]  bcd_bin;
    wire [15:0]   digito;
    wire          busy;
    wire          result_valid;
    wire          error;

    int n_cmp = 0;
    int n_err = 0;
    int div_starts = 0;
    int bcd_starts = 0;
    int snap;

    control_division #(.TIMEOUT_CYC(TO), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .dividendo_in  (dividendo_in),
        .divisor_in    (divisor_in),
        .ver_resto     (ver_resto),
        .div_start     (div_start),
        .div_dividendo (div_dividendo),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_cociente  (div_cociente),
        .div_resto     (div_resto),
        .bcd_start     (bcd_start),
        .bcd_bin       (bcd_bin),
        .bcd_done      (bcd_done),
        .bcd_digits    (bcd_digits),
        .digito        (digito),
        .busy          (busy),
        .result_valid  (result_valid),
        .error         (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start === 1'b1) div_starts++;
        if (bcd_start === 1'b1) bcd_starts++;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int a, input int b);
        dividendo_in = W'(a);
        divisor_in   = W'(b);
        op_valid     = 1'b1;
        tick();
        op_valid     = 1'b0;
    endtask

    task automatic serve_div(input int q, input int r, input int lat);
        repeat (lat) tick();
        div_cociente = W'(q);
        div_resto    = W'(r);
        div_done     = 1'b1;
        tick();
        div_done     = 1'b0;
        div_cociente = '0;
        div_resto    = '0;
    endtask

    task automatic serve_bcd(input int v, input int lat);
        check("bcd_start_hi", {31'd0, bcd_start}, 32'd1);
        check("bcd_bin", {25'd0, bcd_bin}, 32'(v));
        tick();
        check("bcd_start_lo", {31'd0, bcd_start}, 32'd0);
        repeat (lat) tick();
        check("bcd_bin_hold", {25'd0, bcd_bin}, 32'(v));
        bcd_digits = to_bcd(v);
        bcd_done   = 1'b1;
        tick();
        bcd_done   = 1'b0;
        bcd_digits = '0;
    endtask

    task automatic serve_results(input int q, input int r);
        serve_bcd(q, 2);
`ifdef DIVCTRL_RESTO_EN
        serve_bcd(r, 1);
`else
        if (r < 0) $display("remainder %0d", r);
`endif
    endtask

    initial begin
        // Reset behaviour
        #3 rst = 1'b0;
        #1;
        check("rst_digito", {16'd0, digito}, 32'h0);
        check("rst_flags", {27'd0, div_start, bcd_start, busy, result_valid, error}, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 100 / 7 = 14 r 2
        do_op(100, 7);
        check("t1_div_start", {31'd0, div_start}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_dvd", {25'd0, div_dividendo}, 32'd100);
        check("t1_dvs", {25'd0, div_divisor}, 32'd7);
        tick();
        check("t1_div_start_once", {31'd0, div_start}, 32'd0);
        serve_div(14, 2, 3);
        serve_results(14, 2);
        check("t1_valid", {31'd0, result_valid}, 32'd1);
        check("t1_busy_lo", {31'd0, busy}, 32'd0);
        check("t1_quot", {16'd0, digito}, 32'h0014);
        ver_resto = 1'b1;
        tick();
`ifdef DIVCTRL_RESTO_EN
        check("t1_rem", {16'd0, digito}, 32'h0002);
`else
        check("t1_rem_off", {16'd0, digito}, 32'h0014);
`endif
        ver_resto = 1'b0;
        tick();
        check("t1_back_quot", {16'd0, digito}, 32'h0014);

        // Divide by zero, then a valid op from ERR (45 / 6 = 7 r 3)
        snap = div_starts;
        do_op(9, 0);
        check("t2_error", {31'd0, error}, 32'd1);
        check("t2_digito", {16'd0, digito}, 32'hEEEE);
        check("t2_valid", {31'd0, result_valid}, 32'd0);
        tick();
        tick();
        check("t2_no_div_start", 32'(div_starts - snap), 32'd0);
        snap = bcd_starts;
        do_op(45, 6);
        check("t2_error_clr", {31'd0, error}, 32'd0);
        tick();
        serve_div(7, 3, 1);
        serve_results(7, 3);
        check("t2_quot", {16'd0, digito}, 32'h0007);
`ifdef DIVCTRL_RESTO_EN
        check("t2_bcd_starts", 32'(bcd_starts - snap), 32'd2);
`else
        check("t2_bcd_starts", 32'(bcd_starts - snap), 32'd1);
`endif
        ver_resto = 1'b1;
        tick();
`ifdef DIVCTRL_RESTO_EN
        check("t2_rem", {16'd0, digito}, 32'h0003);
`else
        check("t2_rem_off", {16'd0, digito}, 32'h0007);
`endif
        ver_resto = 1'b0;
        tick();

        // Divider timeout: error exactly TO cycles after DIV_WAIT entry
        do_op(50, 5);
        tick();
        repeat (TO - 1) tick();
        check("t3_pre_timeout", {31'd0, error}, 32'd0);
        check("t3_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t3_timeout", {31'd0, error}, 32'd1);
        check("t3_timeout_dig", {16'd0, digito}, 32'hEEEE);
        check("t3_timeout_busy", {31'd0, busy}, 32'd0);

        // Done on the timeout cycle wins (50 / 5 = 10 r 0)
        do_op(50, 5);
        tick();
        serve_div(10, 0, TO - 1);
        check("t3_race_err", {31'd0, error}, 32'd0);
        serve_results(10, 0);
        check("t3_race_quot", {16'd0, digito}, 32'h0010);
        check("t3_race_valid", {31'd0, result_valid}, 32'd1);

        // op_valid during DIV_WAIT is ignored (77 / 8 = 9 r 5)
        do_op(77, 8);
        tick();
        dividendo_in = W'(99);
        divisor_in   = W'(3);
        op_valid     = 1'b1;
        tick();
        op_valid     = 1'b0;
        check("t4_dvd_kept", {25'd0, div_dividendo}, 32'd77);
        check("t4_dvs_kept", {25'd0, div_divisor}, 32'd8);
        check("t4_no_restart", {31'd0, div_start}, 32'd0);
        serve_div(9, 5, 1);
        serve_results(9, 5);
        check("t4_quot", {16'd0, digito}, 32'h0009);

        // Reset during BCDQ_WAIT, then a late bcd_done
        do_op(100, 7);
        tick();
        serve_div(14, 2, 1);
        check("t5_bcd_start", {31'd0, bcd_start}, 32'd1);
        tick();
        check("t5_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_digito", {16'd0, digito}, 32'h0);
        check("t5_rst_flags", {27'd0, div_start, bcd_start, busy, result_valid, error}, 32'h0);
        check("t5_rst_dvd", {25'd0, div_dividendo}, 32'd0);
        tick();
        rst = 1'b1;
        bcd_digits = 16'h0014;
        bcd_done   = 1'b1;
        tick();
        bcd_done   = 1'b0;
        bcd_digits = '0;
        tick();
        check("t5_late_done", {11'd0, digito, busy, result_valid, error, bcd_start, div_start}, 32'h0);

        // Normal operation after reset (20 / 3 = 6 r 2)
        do_op(20, 3);
        check("t5_restart", {31'd0, div_start}, 32'd1);
        tick();
        serve_div(6, 2, 2);
        serve_results(6, 2);
        check("t5_quot", {16'd0, digito}, 32'h0006);
        check("t5_valid", {31'd0, result_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_division.md
CONTROL_DIVISION -- requirements
Module: control_division

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles to wait for any done handshake.
REQ-002 SHALL have parameter W, default 7: operand and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op_valid, input, 1 bit: single-cycle pulse marking that the operands are valid.
REQ-006 SHALL have ports dividendo_in and divisor_in, input, W bits each: the operands.
REQ-007 SHALL have port ver_resto, input, 1 bit: level signal; 1 selects the remainder for display.
REQ-008 SHALL have ports div_start (output, 1 bit), div_dividendo and div_divisor (output, W bits), div_done (input, 1 bit), div_cociente and div_resto (input, W bits): the divider handshake.
REQ-009 SHALL have ports bcd_start (output, 1 bit), bcd_bin (output, W bits), bcd_done (input, 1 bit) and bcd_digits (input, 16 bits): the shared binary-to-BCD converter handshake.
REQ-010 SHALL have ports digito (output, 16 bits), busy, result_valid and error (output, 1 bit each): display word and status.

Function
REQ-011 SHALL implement FSM states IDLE, DIV_START, DIV_WAIT, BCDQ_START, BCDQ_WAIT, BCDR_START, BCDR_WAIT, SHOW and ERR.
REQ-012 SHALL accept op_valid only in IDLE, SHOW or ERR, and SHALL latch both operands into internal registers on that edge.
REQ-013 SHALL ignore op_valid in every other state, with no effect on operands, state or outputs.
REQ-014 SHALL go from an accepting state to ERR when divisor_in==0 on acceptance, without asserting div_start.
REQ-015 SHALL go from an accepting state to DIV_START otherwise.
REQ-016 SHALL assert div_start for exactly one cycle in DIV_START, the cycle after acceptance, with div_dividendo/div_divisor driven from the latched operands and held stable until div_done.
REQ-017 SHALL, in DIV_WAIT, capture div_cociente and div_resto on the div_done cycle and go to BCDQ_START.
REQ-018 SHALL assert bcd_start for one cycle in BCDQ_START with bcd_bin = latched quotient.
REQ-019 SHALL, in BCDQ_WAIT, capture bcd_digits into the quotient BCD register on bcd_done.
REQ-020 SHALL then run the same sequence for the remainder through BCDR_START/BCDR_WAIT, then enter SHOW.
REQ-021 SHALL keep bcd_bin stable from bcd_start until bcd_done.
REQ-022 SHALL, in SHOW, drive digito = remainder BCD when ver_resto=1, else quotient BCD, updating within one cycle of a ver_resto change.
REQ-023 SHALL drive result_valid=1 only in SHOW.
REQ-024 SHALL drive busy=1 in every state from DIV_START through BCDR_WAIT.
REQ-025 SHALL drive error=1 and digito=ERR_PATTERN (16'hEEEE) only in ERR.
REQ-026 SHALL keep a watchdog counter that clears on entry to any *_WAIT state and counts each cycle spent waiting.
REQ-027 SHALL go to ERR when the watchdog reaches TIMEOUT_CYC without the awaited done.
REQ-028 SHALL give a done arriving on the same cycle as the timeout priority over the timeout.
REQ-029 SHALL ignore div_done and bcd_done outside their respective WAIT states.
REQ-030 SHALL register every output; there SHALL be no combinational input-to-output path.

Reset
REQ-031 SHALL, on rst=0 (asynchronous, at any time including mid-operation), force the state to IDLE and clear all operand, result and BCD registers and the watchdog.
REQ-032 SHALL hold digito=16'h0000 and div_start, bcd_start, busy, result_valid and error at 0 during reset.
REQ-033 SHALL leave IDLE on the first op_valid after rst is released.

Configuration
REQ-034 SHALL, with DIVCTRL_RESTO_EN defined, implement the remainder path and ver_resto selection as in REQ-020 and REQ-022.
REQ-035 SHALL, without DIVCTRL_RESTO_EN, omit the BCDR states and remainder registers, go BCDQ_WAIT->SHOW, ignore ver_resto, and always show the quotient.

Structure
REQ-036 SHALL take the state enum, ERR_PATTERN and the default width constants from the shared package div_ctrl_pkg.
REQ-037 SHALL put the watchdog in the sub-module ctrl_timeout (ports: clk, rst, clear, enable, expired; parameter TIMEOUT_CYC).

Verification
REQ-038 SHALL verify: dividendo_in=100, divisor_in=7, op_valid pulse -> div_start one cycle later; with the models, digito=16'h0014, result_valid=1; ver_resto=1 -> digito=16'h0002.
REQ-039 SHALL verify: divisor_in=0, op_valid -> div_start never asserted, error=1, digito=16'hEEEE next cycle; a valid op then -> normal result.
REQ-040 SHALL verify: div_done held 0 -> error=1 exactly TIMEOUT_CYC cycles after DIV_WAIT entry; done and timeout on the same cycle -> no error.
REQ-041 SHALL verify: op_valid pulsed during DIV_WAIT with new operands -> ignored; the result reflects the first operands.
REQ-042 SHALL verify: rst=0 during BCDQ_WAIT -> all outputs 0 immediately, FSM in IDLE; a later late bcd_done has no effect.
REQ-043 SHALL verify: build without DIVCTRL_RESTO_EN, 45/6 -> exactly one bcd_start, digito=16'h0007 regardless of ver_resto.
